// File: rtl/test_result_monitor.sv
// Snoops the CPU data port for per-test result words and tracks pass/fail,
// completion, a run-cycle budget and illegal accesses to the result window.
module test_result_monitor #(
  parameter int unsigned RESULT_BASE    = 256,
  parameter int unsigned NUM_TESTS      = 13,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [31:0]          d_mem_addr,
  input  logic [31:0]          d_mem_wdata,
  input  logic [3:0]           d_mem_wen,
  output logic [NUM_TESTS-1:0] test_written,
  output logic [NUM_TESTS-1:0] test_failed,
  output logic [4:0]           pass_count,
  output logic [4:0]           fail_count,
  output logic [15:0]          cycle_count,
  output logic                 done,
  output logic                 all_pass,
  output logic                 timeout,
  output logic                 bad_write
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  // 33-bit bounds so a window ending at the top of the address space cannot wrap
  localparam logic [32:0] WIN_LO    = 33'(RESULT_BASE);
  localparam logic [32:0] WIN_HI    = 33'(RESULT_BASE + 4 * NUM_TESTS);
  localparam logic [15:0] CYC_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t               state;
  state_t               state_nxt;
  logic                 is_run;
  logic                 in_window;
  logic                 slot_wr;
  logic                 illegal_wr;
  logic [4:0]           slot_idx;
  logic [4:0]           fail_pop;
  logic [NUM_TESTS-1:0] written_nxt;
  logic [NUM_TESTS-1:0] failed_nxt;

  function automatic logic [4:0] popcount(input logic [NUM_TESTS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_TESTS; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  assign is_run     = (state == S_RUN);
  assign in_window  = ({1'b0, d_mem_addr} >= WIN_LO) && ({1'b0, d_mem_addr} < WIN_HI);
  assign slot_idx   = 5'((d_mem_addr - 32'(RESULT_BASE)) >> 2);
  assign slot_wr    = is_run && in_window && (d_mem_wen == 4'b1111) && (d_mem_addr[1:0] == 2'b00);
  assign illegal_wr = is_run && in_window && (d_mem_wen != 4'b0000) &&
                      ((d_mem_wen != 4'b1111) || (d_mem_addr[1:0] != 2'b00));
  assign fail_pop   = popcount(test_written & test_failed);

  always_comb begin
    written_nxt = test_written;
    failed_nxt  = test_failed;
    for (int i = 0; i < NUM_TESTS; i++) begin
      if (slot_wr && (slot_idx == 5'(i))) begin
        written_nxt[i] = 1'b1;
        failed_nxt[i]  = (d_mem_wdata != 32'd0);
      end
    end
  end

  // Completion is judged on the registered slot bits, so DONE follows the
  // last slot write by one edge and takes priority over the budget expiring.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run) state_nxt = S_RUN;
      S_RUN: begin
        if (&test_written)                     state_nxt = S_DONE;
        else if (run && cycle_count == CYC_LIMIT) state_nxt = S_TIMEOUT;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      test_written <= '0;
      test_failed  <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      all_pass     <= 1'b0;
      timeout      <= 1'b0;
      bad_write    <= 1'b0;
    end else begin
      state        <= state_nxt;
      test_written <= written_nxt;
      test_failed  <= failed_nxt;
      pass_count   <= popcount(test_written & ~test_failed);
      fail_count   <= fail_pop;
      // The cycle that leaves RUN is not counted, so a timeout reads TIMEOUT_CYCLES-1
      if (is_run && run && (state_nxt == S_RUN) && (cycle_count != 16'hFFFF))
        cycle_count <= cycle_count + 16'd1;
      done         <= (state_nxt == S_DONE);
      all_pass     <= (state_nxt == S_DONE) && (fail_pop == 5'd0);
      timeout      <= (state_nxt == S_TIMEOUT);
      if (illegal_wr) bad_write <= 1'b1;
    end
  end

endmodule

// File: tb/tb_test_result_monitor.sv
// Bench for test_result_monitor: directed scenarios plus randomized traffic
// checked against a behavioural model of slots, counts and run phase.
module tb_test_result_monitor;

  localparam int NT = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic [31:0]   d_mem_addr = '0;
  logic [31:0]   d_mem_wdata = '0;
  logic [3:0]    d_mem_wen = '0;
  logic [NT-1:0] test_written;
  logic [NT-1:0] test_failed;
  logic [4:0]    pass_count;
  logic [4:0]    fail_count;
  logic [15:0]   cycle_count;
  logic          done;
  logic          all_pass;
  logic          timeout;
  logic          bad_write;

  int checks = 0;
  int errors = 0;

  // behavioural model: phase 0 idle, 1 running, 2 finished, 3 budget expired
  int            m_phase;
  logic [NT-1:0] m_w, m_f;
  int            m_cyc, m_pass, m_fail;
  bit            m_bad, m_allp;

  test_result_monitor dut (
    .clk(clk), .rst(rst), .run(run),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata), .d_mem_wen(d_mem_wen),
    .test_written(test_written), .test_failed(test_failed),
    .pass_count(pass_count), .fail_count(fail_count), .cycle_count(cycle_count),
    .done(done), .all_pass(all_pass), .timeout(timeout), .bad_write(bad_write)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_w = '0; m_f = '0; m_cyc = 0;
    m_pass = 0; m_fail = 0; m_bad = 0; m_allp = 0;
  endtask

  task automatic model_edge(input bit r, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] we);
    int pw, fl;
    bit complete;
    pw = 0; fl = 0;
    for (int i = 0; i < NT; i++) begin
      if (m_w[i] && !m_f[i]) pw++;
      if (m_w[i] && m_f[i]) fl++;
    end
    complete = (m_w == {NT{1'b1}});
    if (m_phase == 0) begin
      if (r) m_phase = 1;
    end else if (m_phase == 1) begin
      if (we != 0 && a >= 256 && a < 256 + 4 * NT) begin
        if (we == 4'hF && a % 4 == 0) begin
          m_w[(a - 256) / 4] = 1'b1;
          m_f[(a - 256) / 4] = (wd != 0);
        end else m_bad = 1;
      end
      if (complete) m_phase = 2;
      else if (r && m_cyc == 1999) m_phase = 3;
      else if (r && m_cyc < 65535) m_cyc++;
    end
    m_pass = pw; m_fail = fl;
    m_allp = (m_phase == 2) && (fl == 0);
  endtask

  task automatic step(input bit r, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] we);
    run = r; d_mem_addr = a; d_mem_wdata = wd; d_mem_wen = we;
    @(posedge clk);
    model_edge(r, a, wd, we);
    #1;
    d_mem_wen = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; d_mem_wen = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({test_written, test_failed, pass_count, fail_count, cycle_count,
         done, all_pass, timeout, bad_write} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: written=%h failed=%h pass=%0d fail=%0d cyc=%0d flags=%b, required all 0",
               test_written, test_failed, pass_count, fail_count, cycle_count,
               {done, all_pass, timeout, bad_write});
    end
    step(0, 32'h100, 0, 4'hF);
    checks++;
    if (test_written !== '0 || cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL idle_ignores: written=%h cyc=%0d, required 0 0", test_written, cycle_count);
    end
  endtask

  task automatic test_all_pass(input int fail_slot);
    do_reset();
    step(1, 0, 0, 4'h0);
    for (int i = 0; i < NT; i++) step(1, 32'h100 + 4 * i, (i == fail_slot) ? 1 : 0, 4'hF);
    checks++;
    if (test_written !== 13'h1FFF || done !== 1'b0) begin
      errors++;
      $display("FAIL last_write_edge: written=%h done=%b, required 1fff 0", test_written, done);
    end
    step(1, 0, 0, 4'h0);
    checks++;
    if (fail_slot < 0) begin
      if (done !== 1 || all_pass !== 1 || pass_count !== 5'd13 || fail_count !== 5'd0 || timeout !== 0) begin
        errors++;
        $display("FAIL all_pass_done: done=%b all_pass=%b pass=%0d fail=%0d to=%b, required 1 1 13 0 0",
                 done, all_pass, pass_count, fail_count, timeout);
      end
    end else begin
      if (done !== 1 || all_pass !== 0 || fail_count !== 5'd1 || pass_count !== 5'd12 ||
          test_failed !== 13'h0008) begin
        errors++;
        $display("FAIL one_fail_done: done=%b all_pass=%b pass=%0d fail=%0d failed=%h, required 1 0 12 1 0008",
                 done, all_pass, pass_count, fail_count, test_failed);
      end
    end
    step(1, 32'h100, 32'h5, 4'hF);
    step(1, 32'h101, 32'h5, 4'h1);
    checks++;
    if (test_failed[0] !== 1'b0 || bad_write !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_frozen: failed0=%b bad=%b done=%b, required 0 0 1",
               test_failed[0], bad_write, done);
    end
  endtask

  task automatic test_rewrite_bad();
    do_reset();
    step(1, 0, 0, 4'h0);
    step(1, 32'h100, 1, 4'hF);
    checks++;
    if (test_failed[0] !== 1'b1 || test_written[0] !== 1'b1) begin
      errors++;
      $display("FAIL first_write_1: failed0=%b written0=%b, required 1 1", test_failed[0], test_written[0]);
    end
    step(1, 32'h100, 0, 4'hF);
    step(1, 32'h200, 7, 4'h1);
    checks++;
    if (test_failed[0] !== 1'b0 || bad_write !== 1'b0) begin
      errors++;
      $display("FAIL rewrite_0: failed0=%b bad=%b, required 0 0", test_failed[0], bad_write);
    end
    step(1, 32'h104, 0, 4'b0001);
    step(1, 0, 0, 4'h0);
    checks++;
    if (bad_write !== 1'b1 || test_written[1] !== 1'b0 || pass_count !== 5'd1) begin
      errors++;
      $display("FAIL byte_write: bad=%b written1=%b pass=%0d, required 1 0 1",
               bad_write, test_written[1], pass_count);
    end
    do_reset();
    step(1, 0, 0, 4'h0);
    step(1, 32'h10A, 0, 4'hF);
    checks++;
    if (bad_write !== 1'b1 || test_written !== '0) begin
      errors++;
      $display("FAIL misaligned: bad=%b written=%h, required 1 0", bad_write, test_written);
    end
  endtask

  task automatic test_timeout();
    int edges;
    do_reset();
    step(1, 0, 0, 4'h0);
    for (int i = 0; i < NT - 1; i++) step(1, 32'h100 + 4 * i, 0, 4'hF);
    edges = NT - 1;
    while (timeout !== 1'b1 && edges < 3000) begin
      step(1, 0, 0, 4'h0);
      edges++;
    end
    checks++;
    if (timeout !== 1 || edges != 2000 || cycle_count !== 16'd1999 || done !== 0) begin
      errors++;
      $display("FAIL timeout_hit: to=%b run_edges=%0d cyc=%0d done=%b, required 1 2000 1999 0",
               timeout, edges, cycle_count, done);
    end
    step(1, 32'h130, 0, 4'hF);
    checks++;
    if (test_written[12] !== 1'b0 || pass_count !== 5'd12 || cycle_count !== 16'd1999) begin
      errors++;
      $display("FAIL timeout_frozen: written12=%b pass=%0d cyc=%0d, required 0 12 1999",
               test_written[12], pass_count, cycle_count);
    end
  endtask

  task automatic test_done_wins();
    int guard;
    do_reset();
    step(1, 0, 0, 4'h0);
    for (int i = 0; i < NT - 1; i++) step(1, 32'h100 + 4 * i, 0, 4'hF);
    guard = 0;
    while (cycle_count !== 16'd1998 && guard < 3000) begin
      step(1, 0, 0, 4'h0);
      guard++;
    end
    step(1, 32'h130, 0, 4'hF);
    checks++;
    if (cycle_count !== 16'd1999 || test_written !== 13'h1FFF || done !== 0 || timeout !== 0) begin
      errors++;
      $display("FAIL race_setup: cyc=%0d written=%h done=%b to=%b, required 1999 1fff 0 0",
               cycle_count, test_written, done, timeout);
    end
    step(1, 0, 0, 4'h0);
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || all_pass !== 1'b1) begin
      errors++;
      $display("FAIL done_wins: done=%b to=%b all_pass=%b, required 1 0 1", done, timeout, all_pass);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, 0, 4'h0);
    for (int i = 0; i < 5; i++) step(1, 32'h100 + 4 * i, i % 2, 4'hF);
    step(1, 32'h104, 0, 4'h3);
    checks++;
    if (test_written !== 13'h001F || bad_write !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: written=%h bad=%b, required 001f 1", test_written, bad_write);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({test_written, test_failed, pass_count, fail_count, cycle_count,
         done, all_pass, timeout, bad_write} !== '0) begin
      errors++;
      $display("FAIL async_reset: written=%h failed=%h pass=%0d fail=%0d cyc=%0d flags=%b, required all 0",
               test_written, test_failed, pass_count, fail_count, cycle_count,
               {done, all_pass, timeout, bad_write});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(0, 32'h100, 0, 4'hF);
    step(1, 32'h100, 0, 4'hF);
    checks++;
    if (test_written !== '0 || cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL resume_idle: written=%h cyc=%0d, required 0 0", test_written, cycle_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic [3:0]  we;
    bit          r;
    int          sel;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int n = 0; n < 120; n++) begin
        sel = $urandom_range(0, 9);
        if (sel <= 6)      a = 32'h100 + 4 * $urandom_range(0, NT - 1);
        else if (sel == 7) a = 32'h100 + $urandom_range(0, 4 * NT - 1);
        else if (sel == 8) a = $urandom_range(0, 255);
        else               a = 32'h100 + 4 * NT + $urandom_range(0, 8);
        we = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
        if (round == 3 && we != 4'hF) we = 4'h0;
        wd = ($urandom_range(0, 4) < 3) ? 32'd0 : $urandom;
        r  = ($urandom_range(0, 9) != 0);
        step(r, a, wd, we);
        checks++;
        if (test_written !== m_w || test_failed !== m_f) begin
          errors++;
          $display("FAIL rand_slots: written=%h failed=%h, required %h %h",
                   test_written, test_failed, m_w, m_f);
        end
        checks++;
        if (pass_count !== 5'(m_pass) || fail_count !== 5'(m_fail) || cycle_count !== 16'(m_cyc) ||
            done !== (m_phase == 2) || timeout !== (m_phase == 3) || all_pass !== m_allp ||
            bad_write !== m_bad) begin
          errors++;
          $display("FAIL rand_status: pass=%0d fail=%0d cyc=%0d d/a/t/b=%b%b%b%b, required %0d %0d %0d %b%b%b%b",
                   pass_count, fail_count, cycle_count, done, all_pass, timeout, bad_write,
                   m_pass, m_fail, m_cyc, m_phase == 2, m_allp, m_phase == 3, m_bad);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_pass(-1);
    test_all_pass(3);
    test_rewrite_bad();
    test_timeout();
    test_done_wins();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_result_monitor.md
TEST_RESULT_MONITOR -- requirements
Module: test_result_monitor

Interface
REQ-001 SHALL have parameter RESULT_BASE, default 256, giving the byte address of test slot 0.
REQ-002 SHALL have parameter NUM_TESTS, default 13, giving the number of one-word result slots (range 1-31).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2000, giving the RUN-state cycle budget (range 1-65535).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port run  input  1  level enable: leaves IDLE; pauses the cycle counter when low.
REQ-007 SHALL have port d_mem_addr  input  32  CPU data-port byte address (snooped).
REQ-008 SHALL have port d_mem_wdata  input  32  CPU data-port write data (snooped).
REQ-009 SHALL have port d_mem_wen  input  4  CPU data-port byte write enables (snooped).
REQ-010 SHALL have port test_written  output  NUM_TESTS  bit i set once slot i has been written.
REQ-011 SHALL have port test_failed  output  NUM_TESTS  bit i = last written value of slot i was nonzero.
REQ-012 SHALL have port pass_count  output  5  number of slots written with a zero value.
REQ-013 SHALL have port fail_count  output  5  number of slots written with a nonzero value.
REQ-014 SHALL have port cycle_count  output  16  number of RUN cycles with run high.
REQ-015 SHALL have port done  output  1  all slots written (DONE state).
REQ-016 SHALL have port all_pass  output  1  done with fail_count == 0.
REQ-017 SHALL have port timeout  output  1  TIMEOUT state.
REQ-018 SHALL have port bad_write  output  1  sticky flag for an illegal access to the result window.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE, TIMEOUT; IDLE->RUN when run=1; DONE and TIMEOUT are terminal until rst.
REQ-020 SHALL treat a valid slot write as d_mem_wen==4'b1111, d_mem_addr[1:0]==0 and RESULT_BASE <= d_mem_addr < RESULT_BASE+4*NUM_TESTS; slot index = (d_mem_addr-RESULT_BASE)>>2.
REQ-021 SHALL, in RUN only, on a valid slot write set test_written[idx] and load test_failed[idx] = (d_mem_wdata != 0), both at the same clock edge.
REQ-022 SHALL let a rewrite of an already-written slot overwrite test_failed[idx]; the final value governs.
REQ-023 SHALL, in RUN, set bad_write for any nonzero d_mem_wen that is not 4'b1111 or that has d_mem_addr[1:0]!=0, with the address inside the window; such accesses leave slot state unchanged.
REQ-024 SHALL ignore writes outside the window, and all writes in IDLE, DONE and TIMEOUT.
REQ-025 SHALL register pass_count and fail_count as the popcount of (written & ~failed) and (written & failed), lagging slot bits by exactly 1 cycle.
REQ-026 SHALL increment cycle_count in RUN when run=1, hold it otherwise, and saturate it at 16'hFFFF.
REQ-027 SHALL transition RUN->DONE on the edge after test_written becomes all ones; done asserts 1 cycle after the last slot bit sets.
REQ-028 SHALL transition RUN->TIMEOUT when cycle_count == TIMEOUT_CYCLES-1 and run=1 and DONE is not being entered; if both occur on the same edge, DONE wins.
REQ-029 SHALL drive all_pass = done & (fail_count==0) as a registered output, valid in the same cycle as done.
REQ-030 SHALL hold all outputs frozen in DONE and TIMEOUT.

Reset
REQ-031 SHALL, on rst high at any time (including mid-RUN), immediately force IDLE, clear test_written, test_failed, both counts, cycle_count, done, all_pass, timeout and bad_write to 0.
REQ-032 SHALL resume from IDLE after rst deasserts, with no state retained.

Verification
REQ-033 SHALL pass: run=1, word writes of 0 to 0x100..0x130 on consecutive cycles -> done=1 and all_pass=1 one cycle after the 0x130 write; pass_count=13, fail_count=0.
REQ-034 SHALL pass: same as REQ-033 but 0x10C is written with 1 -> done=1, all_pass=0, fail_count=1, test_failed=13'h0008.
REQ-035 SHALL pass: slot 0x100 written with 1 then with 0 -> test_failed[0]=0; byte write wen=4'b0001 to 0x104 -> bad_write=1, test_written[1]=0.
REQ-036 SHALL pass: run=1, only 12 slots written -> timeout=1 after 2000 run-cycles, cycle_count=1999, done=0; a later write is ignored.
REQ-037 SHALL pass: the last slot is written on the same edge that cycle_count reaches 1999 -> DONE entered, timeout=0.
REQ-038 SHALL pass: rst pulsed asynchronously mid-RUN with 5 slots written -> all outputs read 0 before the next clk edge.
